ama_riscv_imm_enc: RTL and testbench

- Inverse of the immediate generator: takes a signed/unsigned immediate plus an instruction-format select, and scatters the immediate into RISC-V instruction bits [31:7] over a base instruction word.
- Checks that the immediate is representable in the selected format.
- Used by the assembler/patch path and by self-checking benches that need to build instruction words.
- Two-stage valid/ready pipeline with backpressure and a saturating error counter.

---
 rtl/ama_riscv_imm_pkg.sv | 46 ++++
 rtl/ama_riscv_imm_pack.sv | 56 +++++
 rtl/ama_riscv_imm_enc.sv | 118 +++++++++++
 tb/tb_ama_riscv_imm_enc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_imm_pkg.sv
// Shared select codes, error codes and helpers for the immediate encoder.
// Optional round-trip self-check is enabled by IMM_ENC_ROUNDTRIP_CHK_EN.
package ama_riscv_imm_pkg;

   localparam logic [2:0] IG_DISABLED = 3'b000;
   localparam logic [2:0] IG_I        = 3'b001;
   localparam logic [2:0] IG_S        = 3'b010;
   localparam logic [2:0] IG_B        = 3'b011;
   localparam logic [2:0] IG_J        = 3'b100;
   localparam logic [2:0] IG_U        = 3'b101;

   localparam logic [1:0] IE_ERR_OK       = 2'b00;
   localparam logic [1:0] IE_ERR_RANGE    = 2'b01;
   localparam logic [1:0] IE_ERR_MISALIGN = 2'b10;
   localparam logic [1:0] IE_ERR_INVALID  = 2'b11;

   localparam logic [4:0] IE_MSB_IS = 5'd11;
   localparam logic [4:0] IE_MSB_B  = 5'd12;
   localparam logic [4:0] IE_MSB_J  = 5'd20;

   // True when imm[31:msb] are all copies of the sign bit
   function automatic logic sign_ok(input logic [31:0] imm,
                                    input logic [4:0]  msb);
      logic [31:0] t;
      t = $unsigned($signed(imm) >>> msb);
      return (t == '0) || (t == '1);
   endfunction

   function automatic logic [31:0] rt_decode(input logic [2:0]  sel,
                                             input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      unique case (1'b1)
         (sel == IG_I): r = {{20{w[31]}}, w[31:20]};
         (sel == IG_S): r = {{20{w[31]}}, w[31:25], w[11:7]};
         (sel == IG_B): r = {{19{w[31]}}, w[31], w[7], w[30:25],
                             w[11:8], 1'b0};
         (sel == IG_J): r = {{11{w[31]}}, w[31], w[19:12], w[20],
                             w[30:21], 1'b0};
         (sel == IG_U): r = {w[31:12], 12'b0};
         default:       r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ama_riscv_imm_pack.sv
// Combinational scatter of an immediate into instruction bits [31:7]
// plus representability check.
module ama_riscv_imm_pack
   import ama_riscv_imm_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic [31:0] word,
   output logic [1:0]  err
);

   always_comb begin
      word = base;
      err  = IE_ERR_OK;
      unique case (1'b1)
         (sel == IG_DISABLED): begin
            word = base;
         end
         (sel == IG_I): begin
            word[31:20] = imm[11:0];
            if (!sign_ok(imm, IE_MSB_IS)) err = IE_ERR_RANGE;
         end
         (sel == IG_S): begin
            word[31:25] = imm[11:5];
            word[11:7]  = imm[4:0];
            if (!sign_ok(imm, IE_MSB_IS)) err = IE_ERR_RANGE;
         end
         (sel == IG_B): begin
            word[31]    = imm[12];
            word[30:25] = imm[10:5];
            word[11:8]  = imm[4:1];
            word[7]     = imm[11];
            if (imm[0])                        err = IE_ERR_MISALIGN;
            else if (!sign_ok(imm, IE_MSB_B))  err = IE_ERR_RANGE;
         end
         (sel == IG_J): begin
            word[31]    = imm[20];
            word[30:21] = imm[10:1];
            word[20]    = imm[11];
            word[19:12] = imm[19:12];
            if (imm[0])                        err = IE_ERR_MISALIGN;
            else if (!sign_ok(imm, IE_MSB_J))  err = IE_ERR_RANGE;
         end
         (sel == IG_U): begin
            word[31:12] = imm[31:12];
            if (imm[11:0] != 12'h000) err = IE_ERR_MISALIGN;
         end
         default: begin
            word = base;
            err  = IE_ERR_INVALID;
         end
      endcase
   end

endmodule

// File: rtl/ama_riscv_imm_enc.sv
// Two-stage valid/ready immediate encoder with saturating error counter.
// IMM_ENC_ROUNDTRIP_CHK_EN adds a sticky re-decode mismatch flag.
module ama_riscv_imm_enc
   import ama_riscv_imm_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           ie_sel,
   input  logic [31:0]          ie_imm,
   input  logic [31:0]          ie_base,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          ie_out,
   output logic [1:0]           ie_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_cnt_clr,
   output logic                 rt_mismatch
);

   logic        s1_valid;
   logic [2:0]  s1_sel;
   logic [31:0] s1_imm;
   logic [31:0] s1_base;
   logic [31:0] pk_word;
   logic [1:0]  pk_err;
   logic        s1_adv;
   logic        accept;
   logic        out_hs;

   assign s1_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s1_adv;
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_sel   <= '0;
         s1_imm   <= '0;
         s1_base  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_sel   <= ie_sel;
         s1_imm   <= ie_imm;
         s1_base  <= ie_base;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   ama_riscv_imm_pack u_pack (
      .sel  (s1_sel),
      .imm  (s1_imm),
      .base (s1_base),
      .word (pk_word),
      .err  (pk_err)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         ie_out    <= '0;
         ie_err    <= IE_ERR_OK;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         ie_out    <= pk_word;
         ie_err    <= pk_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Clear wins over a same-cycle errored handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (err_cnt_clr) begin
         err_cnt <= '0;
      end else if (out_hs && (ie_err != IE_ERR_OK) && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

`ifdef IMM_ENC_ROUNDTRIP_CHK_EN
   logic [2:0]  s2_sel;
   logic [31:0] s2_imm;
   logic        rt_flag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_sel <= '0;
         s2_imm <= '0;
      end else if (s1_adv) begin
         s2_sel <= s1_sel;
         s2_imm <= s1_imm;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rt_flag <= 1'b0;
      end else if (out_valid && (ie_err == IE_ERR_OK) &&
                   (s2_sel inside {IG_I, IG_S, IG_B, IG_J, IG_U}) &&
                   (rt_decode(s2_sel, ie_out) != s2_imm)) begin
         rt_flag <= 1'b1;
      end
   end

   assign rt_mismatch = rt_flag;
`else
   assign rt_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_imm_enc.sv
// Scoreboard bench for ama_riscv_imm_enc: directed vectors, backpressure,
// error counter saturation/clear and asynchronous reset.
module tb_ama_riscv_imm_enc;

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ie_sel;
   logic [31:0] ie_imm;
   logic [31:0] ie_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ie_out;
   logic [1:0]  ie_err;
   logic [7:0]  err_cnt;
   logic        err_cnt_clr;
   logic        rt_mismatch;

   exp_t q[$];
   int   ncmp;
   int   nbad;
   int   npop;
   int   mdl_cnt;

   ama_riscv_imm_enc #(.ERR_CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ie_sel      (ie_sel),
      .ie_imm      (ie_imm),
      .ie_base     (ie_base),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ie_out      (ie_out),
      .ie_err      (ie_err),
      .err_cnt     (err_cnt),
      .err_cnt_clr (err_cnt_clr),
      .rt_mismatch (rt_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic send(input logic [2:0] sel, input logic [31:0] imm,
                       input logic [31:0] base, input logic [31:0] w,
                       input logic [1:0] e);
      int n;
      exp_t x;
      in_valid = 1'b1;
      ie_sel   = sel;
      ie_imm   = imm;
      ie_base  = base;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         x.word = w;
         x.err  = e;
         q.push_back(x);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", q.size(), 32'd0);
   endtask

   // Monitor: compare head of queue whenever a result is presented
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               chk("ie_out", ie_out, q[0].word);
               chk("ie_err", {30'd0, ie_err}, {30'd0, q[0].err});
               if (out_ready) begin
                  chk("err_cnt_hs", {24'd0, err_cnt}, mdl_cnt);
                  void'(q.pop_front());
                  npop++;
               end
            end
         end
         if (err_cnt_clr)
            mdl_cnt = 0;
         else if (out_valid && out_ready && ie_err != 2'b00 &&
                  mdl_cnt != 255)
            mdl_cnt++;
      end
   end

   initial begin
      int p0;
      int n;
      ncmp = 0; nbad = 0; npop = 0; mdl_cnt = 0;
      rst = 1'b0;
      in_valid = 1'b0;
      ie_sel = '0; ie_imm = '0; ie_base = '0;
      out_ready = 1'b1;
      err_cnt_clr = 1'b0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ie_out", ie_out, 32'd0);
      chk("rst_ie_err", {30'd0, ie_err}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_rt", {31'd0, rt_mismatch}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Latency: handshake in cycle N, out_valid in cycle N+2
      send(3'b001, 32'hFFFFF800, 32'h00000013, 32'h80000013, 2'b00);
      #1;
      chk("lat_n1", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("lat_n2", {31'd0, out_valid}, 32'd1);
      drain();

      send(3'b010, 32'h00000800, 32'h00002023, 32'h80002023, 2'b01);
      drain();
      @(negedge clk);
      #1;
      chk("err_cnt_1", {24'd0, err_cnt}, 32'd1);

      send(3'b100, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 2'b00);
      send(3'b011, 32'h00000003, 32'h00000063, 32'h00000163, 2'b10);
      send(3'b111, 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11);
      send(3'b101, 32'h12345000, 32'h00000037, 32'h12345037, 2'b00);
      send(3'b101, 32'h12345001, 32'h00000037, 32'h12345037, 2'b10);
      send(3'b000, 32'hFFFFFFFF, 32'h00100093, 32'h00100093, 2'b00);
      send(3'b001, 32'h000007FF, 32'h00000013, 32'h7FF00013, 2'b00);
      send(3'b001, 32'h00000800, 32'h00000013, 32'h80000013, 2'b01);
      send(3'b011, 32'hFFFFF000, 32'h00000063, 32'h80000063, 2'b00);
      send(3'b011, 32'h00001000, 32'h00000063, 32'h80000063, 2'b01);
      send(3'b010, 32'hFFFFFFFF, 32'h00002023, 32'hFE002FA3, 2'b00);
      send(3'b100, 32'h00100000, 32'h0000006F, 32'h8000006F, 2'b01);
      send(3'b110, 32'h00000000, 32'h00000013, 32'h00000013, 2'b11);
      drain();

      // Backpressure: 3 offered, 2 taken while out_ready is low
      p0 = npop;
      out_ready = 1'b0;
      fork
         begin
            send(3'b001, 32'h00000001, 32'h00000013, 32'h00100013, 2'b00);
            send(3'b001, 32'h00000002, 32'h00000013, 32'h00200013, 2'b00);
            send(3'b001, 32'h00000003, 32'h00000013, 32'h00300013, 2'b00);
         end
         begin
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_q_depth", q.size(), 32'd2);
            @(negedge clk);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_results", npop - p0, 32'd3);

      // Saturation
      for (int i = 0; i < 260; i++)
         send(3'b110, i, 32'h00000013, 32'h00000013, 2'b11);
      drain();
      @(negedge clk);
      #1;
      chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

      // Clear together with an errored handshake
      out_ready = 1'b0;
      send(3'b111, 32'h0, 32'h00000033, 32'h00000033, 2'b11);
      n = 0;
      #1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("clr_wait_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      err_cnt_clr = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      err_cnt_clr = 1'b0;
      #1;
      chk("err_cnt_clr", {24'd0, err_cnt}, 32'd0);
      drain();

      // Asynchronous reset with a result pending
      send(3'b110, 32'h0, 32'h00000013, 32'h00000013, 2'b11);
      drain();
      @(negedge clk);
      #1;
      chk("err_cnt_pre_rst", {24'd0, err_cnt}, 32'd1);
      out_ready = 1'b0;
      send(3'b001, 32'h00000004, 32'h00000013, 32'h00400013, 2'b00);
      @(negedge clk);
      #3;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_drop_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_cnt0", {24'd0, err_cnt}, 32'd0);
      q.delete();
      mdl_cnt = 0;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      send(3'b101, 32'hABCDE000, 32'h00000017, 32'hABCDE017, 2'b00);
      drain();
      chk("rt_mismatch", {31'd0, rt_mismatch}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
